// File: rtl/reabastecimento_rolhas_pkg.sv
// Shared state encoding and default constants for the cork refill controller.
package reabastecimento_rolhas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEDIDO,
    ST_CARGA,
    ST_ESPERA_SOLTA,
    ST_FALHA
  } estado_t;

  localparam int LOTE_PADRAO    = 20;
  localparam int MAXIMO_PADRAO  = 99;
  localparam int LIMIAR_PADRAO  = 5;
  localparam int TIMEOUT_PADRAO = 255;

endpackage

// File: rtl/reabastecimento_rolhas_soma_saturada.sv
// Saturating adder: min(count + LOTE, MAXIMO), computed in 8 bits.
module soma_saturada
  import reabastecimento_rolhas_pkg::*;
#(
  parameter int LOTE   = LOTE_PADRAO,
  parameter int MAXIMO = MAXIMO_PADRAO
) (
  input  logic [6:0] count,
  output logic [6:0] soma
);

  localparam logic [7:0] LOTE_W   = 8'(LOTE);
  localparam logic [7:0] MAXIMO_W = 8'(MAXIMO);

  logic [7:0] soma_bruta;

  assign soma_bruta = {1'b0, count} + LOTE_W;
  assign soma       = (soma_bruta > MAXIMO_W) ? MAXIMO_W[6:0] : soma_bruta[6:0];

endmodule

// File: rtl/reabastecimento_rolhas.sv
// Cork refill controller: requests a batch, loads the counter, counts refills.
// Optional refill timeout fault is enabled by defining REFILL_TIMEOUT_EN.
module reabastecimento_rolhas
  import reabastecimento_rolhas_pkg::*;
#(
  parameter int LOTE    = LOTE_PADRAO,
  parameter int MAXIMO  = MAXIMO_PADRAO,
  parameter int LIMIAR  = LIMIAR_PADRAO,
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [6:0] COUNT,
  input  logic       ZERO,
  input  logic       PROD_EN,
  input  logic       MANUAL,
  input  logic       ACK,
  output logic       ENABLE,
  output logic       LOAD,
  output logic [6:0] DADOS,
  output logic       PEDIDO_REQ,
  output logic       ALARME,
  output logic       FALHA,
  output logic [7:0] N_RECARGAS
);

  localparam logic [6:0] LIMIAR_W = 7'(LIMIAR);

  estado_t    state_q, state_d;
  logic [7:0] n_recargas_q, n_recargas_d;
  logic       alarme_q, alarme_d;
  logic       estoque_baixo;
  logic [6:0] soma;

`ifdef REFILL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
  logic [7:0] tmo_q, tmo_d;
`endif

  soma_saturada #(
    .LOTE   (LOTE),
    .MAXIMO (MAXIMO)
  ) u_soma (
    .count (COUNT),
    .soma  (soma)
  );

  assign estoque_baixo = (COUNT <= LIMIAR_W);

  always_comb begin
    state_d      = state_q;
    n_recargas_d = n_recargas_q;
    alarme_d     = estoque_baixo;
`ifdef REFILL_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ZERO || (MANUAL && estoque_baixo)) begin
          state_d = ST_PEDIDO;
`ifdef REFILL_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_PEDIDO: begin
        if (ACK) begin
          state_d = ST_CARGA;
        end
`ifdef REFILL_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_W - 8'd1) begin
          state_d = ST_FALHA;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_CARGA: begin
        state_d      = ST_ESPERA_SOLTA;
        n_recargas_d = n_recargas_q + 8'd1;
      end
      ST_ESPERA_SOLTA: begin
        if (!ACK) state_d = ST_IDLE;
      end
      ST_FALHA: state_d = ST_FALHA;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      n_recargas_q <= '0;
      alarme_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_recargas_q <= n_recargas_d;
      alarme_q     <= alarme_d;
    end
  end

`ifdef REFILL_TIMEOUT_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
  assign FALHA = (state_q == ST_FALHA);
`else
  assign FALHA = 1'b0;
`endif

  // ENABLE is combinational from PROD_EN, so RESET gates it to hold it low during reset
  assign ENABLE     = PROD_EN && (state_q == ST_IDLE) && !ZERO && !RESET;
  assign LOAD       = (state_q == ST_CARGA);
  assign DADOS      = (state_q == ST_CARGA) ? soma : 7'd0;
  assign PEDIDO_REQ = (state_q == ST_PEDIDO);
  assign ALARME     = alarme_q;
  assign N_RECARGAS = n_recargas_q;

endmodule

// File: tb/tb_reabastecimento_rolhas.sv
// Scoreboard bench for reabastecimento_rolhas; covers REFILL_TIMEOUT_EN when defined.
module tb_reabastecimento_rolhas;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [6:0] COUNT;
  logic       ZERO;
  logic       PROD_EN;
  logic       MANUAL;
  logic       ACK;
  logic       ENABLE;
  logic       LOAD;
  logic [6:0] DADOS;
  logic       PEDIDO_REQ;
  logic       ALARME;
  logic       FALHA;
  logic [7:0] N_RECARGAS;

  int checkCount = 0;
  int passCount  = 0;
  int expQ[$];
  int nrecModel  = 0;

  always #5 CLOCK = ~CLOCK;

  reabastecimento_rolhas dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .COUNT      (COUNT),
    .ZERO       (ZERO),
    .PROD_EN    (PROD_EN),
    .MANUAL     (MANUAL),
    .ACK        (ACK),
    .ENABLE     (ENABLE),
    .LOAD       (LOAD),
    .DADOS      (DADOS),
    .PEDIDO_REQ (PEDIDO_REQ),
    .ALARME     (ALARME),
    .FALHA      (FALHA),
    .N_RECARGAS (N_RECARGAS)
  );

  // Compare one observed value against the bench's own expectation
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Reference rule for the load value: batch added, clipped at the ceiling
  function automatic int expDados(input int c);
    return (c + 20 > 99) ? 99 : c + 20;
  endfunction

  // Monitor: every LOAD pops the oldest expected batch; LOAD and ENABLE never overlap
  always @(negedge CLOCK) begin
    checkOutput("load_enable_exclusive", int'(LOAD & ENABLE), 0);
    if (LOAD) begin
      if (expQ.size() == 0) checkOutput("unexpected_load", 1, 0);
      else checkOutput("dados", int'(DADOS), expQ.pop_front());
    end else begin
      checkOutput("dados_outside_carga", int'(DADOS), 0);
    end
  end

  // One refill attempt from IDLE; pushes the expected load only if a request must occur
  task automatic applyStimulus(input int c, input bit z, input bit m);
    bit expectReq;
    int waitCycles;
    int holdCycles;
    int dExp;
    expectReq = z || (m && (c <= 5));
    @(posedge CLOCK); #1;
    COUNT = 7'(c); ZERO = z; MANUAL = m; ACK = 1'b0; PROD_EN = 1'($urandom);
    @(negedge CLOCK);
    checkOutput("enable_idle", int'(ENABLE), int'(PROD_EN & ~z));
    @(posedge CLOCK); #1;
    MANUAL = 1'b0;
    @(negedge CLOCK);
    checkOutput("pedido_req", int'(PEDIDO_REQ), int'(expectReq));
    if (!expectReq) begin
      ZERO = 1'b0;
      return;
    end
    waitCycles = $urandom_range(0, 4);
    repeat (waitCycles) begin
      @(posedge CLOCK); #1;
      PROD_EN = 1'($urandom);
      @(negedge CLOCK);
      checkOutput("enable_blocked_pedido", int'(ENABLE), 0);
    end
    dExp = expDados(c);
    expQ.push_back(dExp);
    @(posedge CLOCK); #1;
    ACK = 1'b1;
    holdCycles = $urandom_range(2, 4);
    repeat (holdCycles) @(posedge CLOCK);
    #1;
    ACK = 1'b0; ZERO = 1'b0; COUNT = 7'(dExp);
    nrecModel = (nrecModel + 1) % 256;
    @(posedge CLOCK);
    @(negedge CLOCK);
    checkOutput("n_recargas", int'(N_RECARGAS), nrecModel);
    checkOutput("pedido_after_refill", int'(PEDIDO_REQ), 0);
  endtask

  initial begin
    int pedCycles;
    bit seenFault;

    RESET = 1'b1; COUNT = 7'd0; ZERO = 1'b0; PROD_EN = 1'b1; MANUAL = 1'b0; ACK = 1'b0;
    #2;
    checkOutput("reset_enable", int'(ENABLE), 0);
    checkOutput("reset_load", int'(LOAD), 0);
    checkOutput("reset_pedido", int'(PEDIDO_REQ), 0);
    checkOutput("reset_alarme", int'(ALARME), 0);
    checkOutput("reset_n_recargas", int'(N_RECARGAS), 0);
    checkOutput("reset_falha", int'(FALHA), 0);
    COUNT = 7'd50;
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;

    $display("[TB] directed refills");
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(3, 1'b0, 1'b1);
    applyStimulus(90, 1'b0, 1'b1);
    applyStimulus(85, 1'b1, 1'b0);
    applyStimulus(5, 1'b1, 1'b1);

    $display("[TB] alarm threshold");
    @(posedge CLOCK); #1 COUNT = 7'd6;
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    checkOutput("alarme_at_6", int'(ALARME), 0);
    @(posedge CLOCK); #1 COUNT = 7'd5;
    @(negedge CLOCK);
    checkOutput("alarme_latency", int'(ALARME), 0);
    @(negedge CLOCK);
    checkOutput("alarme_at_5", int'(ALARME), 1);
    @(posedge CLOCK); #1 COUNT = 7'd6;
    @(negedge CLOCK);
    @(negedge CLOCK);
    checkOutput("alarme_back_6", int'(ALARME), 0);

    $display("[TB] ack ignored in idle");
    @(posedge CLOCK); #1 COUNT = 7'd50; ZERO = 1'b0; ACK = 1'b1;
    repeat (3) begin
      @(negedge CLOCK);
      checkOutput("ack_idle_no_request", int'(PEDIDO_REQ), 0);
    end
    @(posedge CLOCK); #1 ACK = 1'b0;

    $display("[TB] random refills");
    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom_range(0, 99), 1'($urandom), 1'($urandom));
    end

    $display("[TB] reset during request");
    @(posedge CLOCK); #1 COUNT = 7'd0; ZERO = 1'b1;
    @(posedge CLOCK); #1 ZERO = 1'b0; COUNT = 7'd50; PROD_EN = 1'b1;
    @(negedge CLOCK);
    checkOutput("pedido_before_reset", int'(PEDIDO_REQ), 1);
    checkOutput("alarme_before_reset", int'(ALARME), 1);
    @(posedge CLOCK); #1 RESET = 1'b1;
    #1;
    checkOutput("mid_reset_pedido", int'(PEDIDO_REQ), 0);
    checkOutput("mid_reset_enable", int'(ENABLE), 0);
    checkOutput("mid_reset_load", int'(LOAD), 0);
    checkOutput("mid_reset_alarme", int'(ALARME), 0);
    checkOutput("mid_reset_n_recargas", int'(N_RECARGAS), 0);
    ACK = 1'b1;
    nrecModel = 0;
    @(posedge CLOCK); #1 RESET = 1'b0;
    repeat (4) begin
      @(negedge CLOCK);
      checkOutput("after_reset_no_load", int'(LOAD), 0);
    end
    checkOutput("after_reset_n_recargas", int'(N_RECARGAS), 0);
    checkOutput("after_reset_enable", int'(ENABLE), 1);
    @(posedge CLOCK); #1 ACK = 1'b0;

    $display("[TB] long wait in request");
    @(posedge CLOCK); #1 COUNT = 7'd0; ZERO = 1'b1; PROD_EN = 1'b1;
    @(posedge CLOCK); #1 ZERO = 1'b0; COUNT = 7'd50;
    pedCycles = 0;
    seenFault = 1'b0;
`ifdef REFILL_TIMEOUT_EN
    for (int i = 0; i < 300 && !seenFault; i++) begin
      @(negedge CLOCK);
      if (FALHA) seenFault = 1'b1;
      else if (PEDIDO_REQ) pedCycles++;
    end
    checkOutput("falha_reached", int'(seenFault), 1);
    checkOutput("pedido_cycles_before_falha", pedCycles, 255);
    checkOutput("falha_enable", int'(ENABLE), 0);
    checkOutput("falha_pedido", int'(PEDIDO_REQ), 0);
    @(posedge CLOCK); #1 ACK = 1'b1;
    repeat (5) @(negedge CLOCK);
    checkOutput("falha_sticky", int'(FALHA), 1);
    checkOutput("falha_no_load", int'(LOAD), 0);
    @(posedge CLOCK); #1 ACK = 1'b0;
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      if (FALHA) seenFault = 1'b1;
      if (PEDIDO_REQ) pedCycles++;
    end
    checkOutput("no_falha_without_timeout", int'(seenFault), 0);
    checkOutput("pedido_held", pedCycles, 300);
    checkOutput("enable_held_low", int'(ENABLE), 0);
`endif
    @(posedge CLOCK); #1 RESET = 1'b1;
    #1;
    checkOutput("reset_clears_falha", int'(FALHA), 0);
    checkOutput("reset_clears_pedido", int'(PEDIDO_REQ), 0);
    nrecModel = 0;
    @(posedge CLOCK); #1 RESET = 1'b0;

    $display("[TB] refill counter wrap");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 1'b1, 1'b0);
    end
    checkOutput("n_recargas_wrap", int'(N_RECARGAS), 0);

    repeat (3) @(negedge CLOCK);
    checkOutput("pending_loads", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reabastecimento_rolhas.md
REABASTECIMENTO_ROLHAS -- requirements
Module: reabastecimento_rolhas

Interface
REQ-001 Parameter LOTE, default 20: corks added per refill.
REQ-002 Parameter MAXIMO, default 99: saturation ceiling for the loaded value.
REQ-003 Parameter LIMIAR, default 5: low-stock alarm threshold.
REQ-004 Parameter TIMEOUT, default 255: cycles allowed in PEDIDO before fault; 8-bit.
REQ-005 CLOCK  input  1  single system clock, rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 COUNT  input  7  current cork count from the cork down-counter.
REQ-008 ZERO  input  1  counter-empty flag from the cork down-counter.
REQ-009 PROD_EN  input  1  production requests a decrement (one cork consumed).
REQ-010 MANUAL  input  1  operator request for an early refill.
REQ-011 ACK  input  1  operator/feeder confirms the batch is physically inserted; level signal.
REQ-012 ENABLE  output  1  decrement enable driven to the counter.
REQ-013 LOAD  output  1  parallel-load strobe to the counter.
REQ-014 DADOS  output  7  parallel-load value to the counter.
REQ-015 PEDIDO_REQ  output  1  refill request to the operator/feeder.
REQ-016 ALARME  output  1  low-stock indication.
REQ-017 FALHA  output  1  refill timeout fault.
REQ-018 N_RECARGAS  output  8  number of completed refills.

Function
REQ-019 The FSM SHALL have states IDLE, PEDIDO, CARGA, ESPERA_SOLTA and FALHA.
REQ-020 IDLE->PEDIDO when ZERO=1, or when MANUAL=1 and COUNT<=LIMIAR; ZERO has priority, and the result is identical when both hold.
REQ-021 PEDIDO: PEDIDO_REQ=1; ->CARGA on the first cycle ACK=1.
REQ-022 CARGA lasts exactly one cycle: LOAD=1, DADOS=min(COUNT+LOTE, MAXIMO) computed in 8 bits from COUNT in that same cycle; ->ESPERA_SOLTA.
REQ-023 Outside CARGA: LOAD=0 and DADOS=0.
REQ-024 ESPERA_SOLTA: ->IDLE on the first cycle ACK=0; N_RECARGAS increments once on entry, wrapping 255->0.
REQ-025 ENABLE = PROD_EN AND state==IDLE AND NOT ZERO; the counter never decrements while a refill is in progress.
REQ-026 ALARME = (COUNT<=LIMIAR), registered, one-cycle latency; it is independent of FSM state.
REQ-027 ACK=1 while in IDLE SHALL be ignored; a request requires a fresh ACK edge sequence only in the sense that ACK must be sampled in PEDIDO.
REQ-028 LOAD and ENABLE SHALL never be 1 in the same cycle.
REQ-029 FALHA state: FALHA=1, ENABLE=0, PEDIDO_REQ=0; it is exited only by RESET.

Reset
REQ-030 RESET SHALL asynchronously force state IDLE, and ENABLE/LOAD/PEDIDO_REQ/FALHA=0, DADOS=0, N_RECARGAS=0, ALARME=0, timeout counter=0.
REQ-031 A RESET during PEDIDO or CARGA SHALL abort the refill with no LOAD issued after release and no N_RECARGAS increment.

Configuration
REQ-032 Macro REFILL_TIMEOUT_EN: when defined, an 8-bit counter clears on PEDIDO entry and increments each PEDIDO cycle; if it reaches TIMEOUT with ACK=0, the FSM SHALL go ->FALHA.
REQ-033 Without REFILL_TIMEOUT_EN, PEDIDO waits indefinitely, FALHA is tied to 0, and the FALHA state is unreachable.

Structure
REQ-034 A shared package SHALL hold the state enumeration and the default constants LOTE=20, MAXIMO=99, LIMIAR=5.
REQ-035 The saturating adder min(COUNT+LOTE, MAXIMO) SHALL be one sub-module, soma_saturada.

Verification
REQ-036 COUNT=0, ZERO=1 -> next cycle PEDIDO_REQ=1, ENABLE=0; ACK=1 -> one cycle LOAD=1, DADOS=20; ACK=0 -> IDLE, N_RECARGAS=1.
REQ-037 COUNT=3, MANUAL=1, ACK -> DADOS=23; COUNT=90, MANUAL=1 -> no request (90>LIMIAR); forced COUNT=85 via ZERO path with LOTE=20 -> DADOS=99.
REQ-038 COUNT falls 6->5 -> ALARME=1 one cycle later; COUNT=6 -> ALARME=0.
REQ-039 With REFILL_TIMEOUT_EN, enter PEDIDO, hold ACK=0 for 255 cycles -> FALHA=1, ENABLE=0; holds until RESET.
REQ-040 RESET pulse mid-PEDIDO -> all outputs 0 immediately; with ACK=1 held after release and COUNT>LIMIAR, ZERO=0 -> no LOAD.
REQ-041 256 complete refill cycles -> N_RECARGAS wraps to 0; LOAD and ENABLE are never both 1 (assertion).
